// File: rtl/dedisp_boxcar_detect.sv
// Frame integrator, boxcar matched filter and threshold detector for the dedispersed stream.
// Optional `DEDISP_PEAK_HOLD_EN: report the peak of each threshold crossing instead of first-crossing + holdoff.
module dedisp_boxcar_detect #(
  parameter int DIN_WIDTH = 25,
  parameter int ACC_WIDTH = 32,
  parameter int BOX_LOG2  = 3,
  parameter int TS_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic [DIN_WIDTH-1:0]          din,
  input  logic                          din_valid,
  input  logic                          din_sof,
  input  logic                          din_eof,
  input  logic [BOX_LOG2:0]             box_len,
  input  logic [ACC_WIDTH+BOX_LOG2-1:0] threshold,
  output logic [ACC_WIDTH-1:0]          frame_pow,
  output logic                          frame_valid,
  output logic [ACC_WIDTH+BOX_LOG2-1:0] box_pow,
  output logic                          box_valid,
  output logic                          detect,
  output logic [ACC_WIDTH+BOX_LOG2-1:0] detect_pow,
  output logic [TS_WIDTH-1:0]           detect_ts,
  output logic [TS_WIDTH-1:0]           frame_cnt
);

  localparam int BOX_W = ACC_WIDTH + BOX_LOG2;
  localparam int DEPTH = 1 << BOX_LOG2;
  localparam int LEN_W = BOX_LOG2 + 1;

  typedef enum logic {IDLE, ACC} state_t;

  // ---------------- frame integrator ----------------
  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt, acc_sat, din_ext;
  logic [ACC_WIDTH:0]   acc_wide;
  logic                 close;
  logic                 frame_valid_q;
  logic [TS_WIDTH-1:0]  frame_ts;

  assign din_ext  = ACC_WIDTH'(din);
  assign acc_wide = {1'b0, acc} + {1'b0, din_ext};
  assign acc_sat  = acc_wide[ACC_WIDTH] ? '1 : acc_wide[ACC_WIDTH-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    close     = 1'b0;
    case (state)
      IDLE: if (din_valid && din_sof) begin
        acc_nxt = din_ext;
        if (din_eof) close = 1'b1;
        else         state_nxt = ACC;
      end
      ACC: if (din_valid) begin
        // sof inside a frame drops the partial sum and starts over
        acc_nxt = din_sof ? din_ext : acc_sat;
        if (din_eof) begin
          close     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      frame_valid_q <= 1'b0;
      frame_pow     <= '0;
      frame_ts      <= '0;
      frame_cnt     <= '0;
    end else if (ce) begin
      state         <= state_nxt;
      acc           <= acc_nxt;
      frame_valid_q <= close;
      if (close) begin
        frame_pow <= acc_nxt;
        frame_ts  <= frame_cnt;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // ---------------- boxcar ----------------
  logic [ACC_WIDTH-1:0] hist [DEPTH];
  logic [BOX_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [LEN_W-1:0]     eff_len, prev_len, fill, fill_nxt;
  logic [ACC_WIDTH-1:0] old_pow;
  logic [BOX_W-1:0]     sum_nxt;
  logic                 len_change;
  logic                 box_valid_q;
  logic [TS_WIDTH-1:0]  box_ts;

  always_comb begin
    if (box_len == '0)                 eff_len = LEN_W'(1);
    else if (box_len > LEN_W'(DEPTH))  eff_len = LEN_W'(DEPTH);
    else                               eff_len = box_len;
  end

  // prev_len resets to 0, never a legal length, so the first frame always restarts the boxcar
  assign len_change = (eff_len != prev_len);
  assign rd_ptr     = wr_ptr - eff_len[BOX_LOG2-1:0];
  assign old_pow    = (fill >= eff_len) ? hist[rd_ptr] : '0;
  assign sum_nxt    = len_change ? BOX_W'(frame_pow)
                                 : box_pow + BOX_W'(frame_pow) - BOX_W'(old_pow);
  assign fill_nxt   = len_change ? LEN_W'(1)
                    : (fill == LEN_W'(DEPTH)) ? fill : fill + 1'b1;

  // NOTE: history RAM has no reset; fill count masks stale entries, keeping it a plain RAM.
  always_ff @(posedge clk) begin
    if (ce && frame_valid_q) hist[wr_ptr] <= frame_pow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      box_pow     <= '0;
      box_valid_q <= 1'b0;
      box_ts      <= '0;
      fill        <= '0;
      prev_len    <= '0;
      wr_ptr      <= '0;
    end else if (ce) begin
      box_valid_q <= 1'b0;
      if (frame_valid_q) begin
        box_pow     <= sum_nxt;
        box_valid_q <= (fill_nxt >= eff_len);
        box_ts      <= frame_ts;
        fill        <= fill_nxt;
        prev_len    <= eff_len;
        wr_ptr      <= wr_ptr + 1'b1;
      end
    end
  end

  // ---------------- detector ----------------
  logic detect_q;

`ifdef DEDISP_PEAK_HOLD_EN
  logic                in_event;
  logic [BOX_W-1:0]    peak_pow;
  logic [TS_WIDTH-1:0] peak_ts;

  always_ff @(posedge clk) begin
    if (rst) begin
      detect_q   <= 1'b0;
      detect_pow <= '0;
      detect_ts  <= '0;
      in_event   <= 1'b0;
      peak_pow   <= '0;
      peak_ts    <= '0;
    end else if (ce) begin
      detect_q <= 1'b0;
      if (box_valid_q) begin
        if (box_pow > threshold) begin
          if (!in_event || box_pow > peak_pow) begin
            peak_pow <= box_pow;
            peak_ts  <= box_ts;
          end
          in_event <= 1'b1;
        end else if (in_event) begin
          detect_q   <= 1'b1;
          detect_pow <= peak_pow;
          detect_ts  <= peak_ts;
          in_event   <= 1'b0;
        end
      end
    end
  end
`else
  logic [LEN_W-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      detect_q   <= 1'b0;
      detect_pow <= '0;
      detect_ts  <= '0;
      hold_cnt   <= '0;
    end else if (ce) begin
      detect_q <= 1'b0;
      if (box_valid_q) begin
        if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - 1'b1;
        end else if (box_pow > threshold) begin
          // the detecting frame is the first of box_len frames in holdoff
          detect_q   <= 1'b1;
          detect_pow <= box_pow;
          detect_ts  <= box_ts;
          hold_cnt   <= prev_len - 1'b1;
        end
      end
    end
  end
`endif

  // pulses are masked while ce is low; the underlying state is frozen
  assign frame_valid = frame_valid_q & ce;
  assign box_valid   = box_valid_q & ce;
  assign detect      = detect_q & ce;

endmodule
